// File: rtl/alu_div_seq.sv
// Multi-cycle radix-2 restoring divider for the ALU divide/remainder ops.
// One quotient bit per CALC cycle; the result is registered on entry to DONE.
module alu_div_seq #(
  parameter int         WIDTH  = 64,
  parameter logic [4:0] OPDIV  = 5'd15,
  parameter logic [4:0] OPDIVU = 5'd16,
  parameter logic [4:0] OPREM  = 5'd17,
  parameter logic [4:0] OPREMU = 5'd18
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic             iKill,
  input  logic [4:0]       iControl,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oValid,
  output logic [WIDTH-1:0] oResult
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, dvs;
  logic             neg_q, neg_r, sel_rem;

  logic             is_sdiv, is_rem, is_div;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div0, ovf, special, accept;
  logic [WIDTH-1:0] spec_res;

  assign is_sdiv = (iControl == OPDIV) || (iControl == OPREM);
  assign is_rem  = (iControl == OPREM) || (iControl == OPREMU);
  assign is_div  = is_sdiv || (iControl == OPDIVU)
                 || (iControl == OPREMU);

  assign sign_a = is_sdiv & iA[WIDTH-1];
  assign sign_b = is_sdiv & iB[WIDTH-1];
  assign mag_a  = sign_a ? -iA : iA;
  assign mag_b  = sign_b ? -iB : iB;

  assign div0    = (iB == '0);
  assign ovf     = is_sdiv && (iA == MIN_NEG) && (iB == '1);
  assign special = div0 || ovf;
  assign accept  = (state == IDLE) && iStart && is_div;

  always_comb begin
    spec_res = '0;
    if (div0)
      spec_res = is_rem ? iA : '1;
    else if (!is_rem)
      spec_res = iA;
  end

  // Compare in WIDTH+1 bits so a divisor with its MSB set still works.
  logic [WIDTH-1:0] rem_lo, rem_nx, dvd_nx;
  logic [WIDTH:0]   diff;
  logic             ge;

  assign rem_lo = {rem[WIDTH-2:0], dvd[WIDTH-1]};
  assign diff   = {rem[WIDTH-1], rem_lo} - {1'b0, dvs};
  assign ge     = ~diff[WIDTH];
  assign rem_nx = ge ? diff[WIDTH-1:0] : rem_lo;
  assign dvd_nx = {dvd[WIDTH-2:0], ge};

  logic [WIDTH-1:0] fin;
  always_comb begin
    fin = '0;
    if (sel_rem)
      fin = neg_r ? -rem_nx : rem_nx;
    else
      fin = neg_q ? -dvd_nx : dvd_nx;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (iKill) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_n = special ? DONE : CALC;
        CALC: if (cnt == '0) state_n = DONE;
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    oBusy  = (state == CALC);
    oValid = (state == DONE);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rem     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
      oResult <= '0;
    end else if (!iKill) begin
      if (accept) begin
        rem     <= '0;
        dvd     <= mag_a;
        dvs     <= mag_b;
        cnt     <= CW'(WIDTH-1);
        neg_q   <= sign_a ^ sign_b;
        neg_r   <= sign_a;
        sel_rem <= is_rem;
        if (special)
          oResult <= spec_res;
      end else if (state == CALC) begin
        rem <= rem_nx;
        dvd <= dvd_nx;
        cnt <= cnt - 1'b1;
        if (cnt == '0)
          oResult <= fin;
      end
    end
  end

endmodule

// File: doc/alu_div_seq.md
# alu_div_seq

Multi-cycle sequencer for the ALU divide/remainder operations (OPDIV, OPDIVU, OPREM, OPREMU). It captures operands on a start pulse and runs a radix-2 restoring shift-subtract loop for WIDTH cycles. It then presents a registered result for one cycle with a valid strobe. It sits beside the combinational ALU in the execute stage, which holds the instruction while oBusy is high.

## Interface
Parameters:
- WIDTH, 64, operand and result width; must be ≥ 2.

Ports:
- iCLK  in  1  clock; all state updates on the rising edge.
- iRST  in  1  reset, asynchronous, active-high; forces IDLE and clears every register.
- iStart  in  1  request pulse, sampled only in IDLE.
- iKill  in  1  pipeline flush; aborts any operation in progress.
- iControl  in  5  ALU opcode from Parametros.v; only OPDIV, OPDIVU, OPREM and OPREMU are accepted.
- iA  in  WIDTH  dividend.
- iB  in  WIDTH  divisor.
- oBusy  out  1  high in CALC.
- oValid  out  1  high for exactly one cycle, in DONE.
- oResult  out  WIDTH  quotient or remainder; registered.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: iterating.
  - DONE: result available.
- IDLE → CALC on iStart when iControl is a divide op and the operation is not a special case.
- IDLE → DONE directly on iStart for special cases:
  - divisor == 0: quotient = all ones; remainder = iA (all four ops).
  - Signed overflow (OPDIV/OPREM, iA = most-negative, iB = −1): quotient = iA; remainder = 0.
- iStart with any other opcode: ignored; stay in IDLE.
- Capture on start: op kind (signed yes/no, quotient or remainder) and operand magnitudes.
  - Signed ops: |iA| and |iB| (two's-complement negate if MSB set). Record negQ = signA XOR signB and negR = signA.
  - Unsigned ops: operands used raw; negQ = negR = 0.
- CALC, each cycle:
  - rem = {rem[WIDTH-2:0], dvd[WIDTH-1]}; dvd shifts left 1.
  - If rem ≥ divisor: rem −= divisor and the quotient LSB is 1; otherwise 0.
  - Iteration counter loads WIDTH−1 on entry and decrements each CALC cycle. The transition to DONE occurs on the cycle the counter is 0.
  - The comparison uses a WIDTH+1-bit subtraction, so a divisor MSB of 1 is handled for unsigned ops.
- Entry to DONE: oResult is loaded with the selected value. The quotient is negated if negQ; the remainder is negated if negR.
- DONE → IDLE unconditionally on the next edge. oResult holds its value until the next load.
- iStart while in CALC or DONE: ignored. The requester must hold and re-issue the request after oValid.
- iKill: any state → IDLE on the next edge. oValid is not asserted and oResult is unchanged. iKill takes priority over iStart and over completion.
- Reset values: state = IDLE, oBusy = 0, oValid = 0, oResult = 0, counter = 0, all internal registers = 0.

## Timing
- Normal latency, with iStart sampled at edge t:
  - oBusy high from t to t+WIDTH.
  - oValid and oResult valid between edges t+WIDTH and t+WIDTH+1.
  - For WIDTH = 64 this is 64 cycles.
- Special-case latency: oValid in the cycle after edge t; oBusy never rises.
- Earliest next accepted iStart: the edge that leaves DONE is not an IDLE sample. The next start is accepted at edge t+WIDTH+2, which gives back-to-back throughput of WIDTH+2 cycles.
- oBusy and oValid are decoded from the state register only, with no combinational path from inputs. They are never high in the same cycle.
- iRST asserted mid-CALC: outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- OPDIVU, iA = 100, iB = 7 → oBusy high for 64 cycles, then oValid with oResult = 14. The same operands with OPREMU → 2.
- OPDIV, iA = −100, iB = 7 → oResult = −14. OPREM with the same operands → −2. OPDIV, iA = 100, iB = −7 → −14.
- Divide by zero: OPDIVU with iB = 0 → oValid one cycle after start, oResult = 0xFFFF_FFFF_FFFF_FFFF. OPREM, iA = 5, iB = 0 → 5.
- Overflow: OPDIV, iA = 0x8000_0000_0000_0000, iB = −1 → oResult = 0x8000_0000_0000_0000 after 1 cycle. OPREM with the same operands → 0.
- OPDIVU, iA = 0xFFFF_FFFF_FFFF_FFFF, iB = 0x8000_0000_0000_0001 → 1. iKill at CALC cycle 10 → IDLE next cycle, no oValid, oResult unchanged. iStart with OPADD → ignored.
- iRST asserted at CALC cycle 30 → oBusy drops asynchronously. After release, a fresh OPDIVU 9/3 → 3. Back-to-back starts verify the WIDTH+2 spacing.
